// File: rtl/intr_ctrl.sv
// N-channel interrupt aggregator: synchronises raw sources, latches edge/level pending
// bits, masks them and presents the lowest-index enabled request as a registered irq/irq_id.
module intr_ctrl #(
    parameter int N    = 8,
    parameter int SYNC = 2,
    parameter int INIT = 0
) (
    input  logic                                   clk,
    input  logic                                   nst_rst,
    input  logic [N-1:0]                           src,
    input  logic [N-1:0]                           mode,
    input  logic [N-1:0]                           pol,
    input  logic [N-1:0]                           en,
    input  logic [N-1:0]                           clr,
    input  logic                                   ack,
    output logic [N-1:0]                           pend,
    output logic                                   irq,
    output logic [($clog2(N) > 0 ? $clog2(N) : 1)-1:0] irq_id
);

    localparam int IDW = ($clog2(N) > 0) ? $clog2(N) : 1;
    localparam int AW  = $clog2(SYNC + 2);
    localparam logic [AW-1:0] ARM_DONE = AW'(SYNC + 1);
    localparam logic [N-1:0]  INIT_VEC = (INIT != 0) ? {N{1'b1}} : {N{1'b0}};

    // Handshake: ack is a one-cycle claim of the irq_id presented in the same cycle;
    // it only takes effect when irq is also high, otherwise it is dropped.

    logic [SYNC-1:0][N-1:0] sync_q;
    logic [N-1:0]           s;
    logic [N-1:0]           s_d;
    logic [AW-1:0]          arm_cnt;
    logic                   armed;
    logic [N-1:0]           set_v;
    logic [N-1:0]           clr_v;
    logic [N-1:0]           pend_nxt;
    logic [N-1:0]           act;
    logic                   irq_nxt;
    logic [IDW-1:0]         id_nxt;

    assign s     = sync_q[SYNC-1];
    assign armed = (arm_cnt == ARM_DONE);

    // Sources are normalised before the chain so every stage reads 1 = active.
    always_ff @(posedge clk or posedge nst_rst) begin
        if (nst_rst) begin
            sync_q  <= '0;
            s_d     <= '0;
            arm_cnt <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC-2:0], src ^ ~pol};
            s_d     <= s;
            if (!armed)
                arm_cnt <= arm_cnt + AW'(1);
        end
    end

    always_comb begin
        set_v = '0;
        clr_v = clr;
        if (armed)
            set_v = s & ~s_d;
        if (ack && irq)
            clr_v = clr | (N'(1) << irq_id);
        // Set takes precedence over clear so a fresh event is never lost.
        pend_nxt = (mode & (set_v | (pend & ~clr_v))) | (~mode & s);
    end

    always_comb begin
        act     = pend & en;
        irq_nxt = |act;
        id_nxt  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (act[i])
                id_nxt = IDW'(i);
        end
    end

    always_ff @(posedge clk or posedge nst_rst) begin
        if (nst_rst) begin
            pend   <= INIT_VEC & mode;
            irq    <= 1'b0;
            irq_id <= '0;
        end else begin
            pend   <= pend_nxt;
            irq    <= irq_nxt;
            irq_id <= id_nxt;
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed testbench for intr_ctrl (N=8, SYNC=2, INIT=0): inputs change and outputs
// are checked on the falling edge, expected values are hand-computed constants.
module tb_intr_ctrl;

    localparam int N = 8;

    logic         clk;
    logic         nst_rst;
    logic [N-1:0] src;
    logic [N-1:0] mode;
    logic [N-1:0] pol;
    logic [N-1:0] en;
    logic [N-1:0] clr;
    logic         ack;
    logic [N-1:0] pend;
    logic         irq;
    logic [2:0]   irq_id;

    int vectors;
    int errors;

    intr_ctrl #(.N(N), .SYNC(2), .INIT(0)) dut (
        .clk     (clk),
        .nst_rst (nst_rst),
        .src     (src),
        .mode    (mode),
        .pol     (pol),
        .en      (en),
        .clr     (clr),
        .ack     (ack),
        .pend    (pend),
        .irq     (irq),
        .irq_id  (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e_pend, input logic e_irq,
                           input logic [2:0] e_id);
        chk({tag, ".pend"}, 32'(pend), 32'(e_pend));
        chk({tag, ".irq"}, 32'(irq), 32'(e_irq));
        chk({tag, ".id"}, 32'(irq_id), 32'(e_id));
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        nst_rst = 1'b1;
        src     = '0;
        mode    = 8'hFF;
        pol     = 8'hFF;
        en      = 8'hFF;
        clr     = '0;
        ack     = 1'b0;
        step(3);
        chk_out("reset_init", 8'h00, 1'b0, 3'd0);
        nst_rst = 1'b0;
        step(5);
        chk_out("idle", 8'h00, 1'b0, 3'd0);

        // Single rising edge on channel 3 and its claim
        src[3] = 1'b1;
        step(2);
        chk("edge3_early.pend", 32'(pend), 32'h00);
        step(1);
        chk_out("edge3_pend", 8'h08, 1'b0, 3'd0);
        step(1);
        chk_out("edge3_irq", 8'h08, 1'b1, 3'd3);
        pulse_ack();
        chk_out("edge3_ack1", 8'h00, 1'b1, 3'd3);
        step(1);
        chk_out("edge3_ack2", 8'h00, 1'b0, 3'd0);
        src[3] = 1'b0;
        step(4);

        // Reset mid-traffic: channel 0 pending, then async reset between edges
        src[0] = 1'b1;
        step(4);
        chk_out("pre_rst", 8'h01, 1'b1, 3'd0);
        #2 nst_rst = 1'b1;
        #1 chk_out("async_rst", 8'h00, 1'b0, 3'd0);
        pol = 8'h00;
        src = 8'h00;
        step(2);
        nst_rst = 1'b0;
        step(6);
        chk_out("post_rst_actlow", 8'h00, 1'b0, 3'd0);
        pol = 8'hFF;
        step(4);
        chk_out("pol_restore", 8'h00, 1'b0, 3'd0);

        // Priority between simultaneous and late-arriving edges
        src[5] = 1'b1;
        src[2] = 1'b1;
        step(3);
        chk("prio_pend", 32'(pend), 32'h24);
        step(1);
        chk_out("prio_2", 8'h24, 1'b1, 3'd2);
        pulse_ack();
        step(1);
        chk_out("prio_5", 8'h20, 1'b1, 3'd5);
        src[1] = 1'b1;
        step(3);
        chk("prio_pend1", 32'(pend), 32'h22);
        step(1);
        chk_out("prio_1", 8'h22, 1'b1, 3'd1);
        pulse_ack();
        step(1);
        chk_out("prio_back5", 8'h20, 1'b1, 3'd5);
        pulse_ack();
        step(1);
        chk_out("prio_empty", 8'h00, 1'b0, 3'd0);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk_out("ack_no_irq", 8'h00, 1'b0, 3'd0);
        src = 8'h00;
        step(4);

        // Clear colliding with a detected edge: set wins
        src[4] = 1'b1;
        step(2);
        clr[4] = 1'b1;
        step(1);
        clr[4] = 1'b0;
        chk("collide_pend", 32'(pend), 32'h10);
        src[4] = 1'b0;
        step(4);
        src[4] = 1'b1;
        step(4);
        chk_out("coalesce", 8'h10, 1'b1, 3'd4);
        pulse_ack();
        step(1);
        chk_out("coalesce_ack", 8'h00, 1'b0, 3'd0);
        src[4] = 1'b0;
        step(4);
        src[4] = 1'b1;
        step(4);
        chk("w1c_set.pend", 32'(pend), 32'h10);
        clr[4] = 1'b1;
        step(1);
        clr[4] = 1'b0;
        chk("w1c_clr.pend", 32'(pend), 32'h00);
        src[4] = 1'b0;
        step(4);

        // Level channel with enable mask
        mode = 8'hBF;
        en   = 8'hBF;
        src[6] = 1'b1;
        step(3);
        chk("level_pend", 32'(pend), 32'h40);
        step(1);
        chk_out("level_masked", 8'h40, 1'b0, 3'd0);
        en = 8'hFF;
        step(1);
        chk_out("level_unmask", 8'h40, 1'b1, 3'd6);
        ack = 1'b1;
        clr = 8'h40;
        step(1);
        ack = 1'b0;
        clr = 8'h00;
        step(1);
        chk_out("level_noclr", 8'h40, 1'b1, 3'd6);
        src[6] = 1'b0;
        step(2);
        chk("level_hold.pend", 32'(pend), 32'h40);
        step(1);
        chk("level_drop.pend", 32'(pend), 32'h00);
        step(1);
        chk_out("level_idle", 8'h00, 1'b0, 3'd0);
        mode = 8'hFF;
        step(2);

        // Active-low (falling) channel 7
        src[7] = 1'b1;
        pol[7] = 1'b0;
        step(4);
        chk_out("pol_idle", 8'h00, 1'b0, 3'd0);
        src[7] = 1'b0;
        step(3);
        chk("pol_fall.pend", 32'(pend), 32'h80);
        step(1);
        chk_out("pol_fall", 8'h80, 1'b1, 3'd7);
        pulse_ack();
        step(1);
        chk_out("pol_ack", 8'h00, 1'b0, 3'd0);
        src[7] = 1'b1;
        step(4);
        chk_out("pol_rise", 8'h00, 1'b0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
